// File: rtl/control_sequencer.sv
// Moore control unit: fetch, decode on T3 entry, per-class execute steps T3..T7.
// Latency: fetch is 4 cycles at MEM_WAIT=1. Each strobe is high for its whole state cycle.
// Backpressure: none. Stop halts only at an instruction boundary, and clear low forces all outputs to 0.
module control_sequencer #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       Clock,
   input  logic       clear,
   input  logic [4:0] opcode,
   input  logic       CON,
   input  logic       Stop,
   output logic       Run,
   output logic       illegal,
   output logic       PCout, Zlowout, Zhighout, HIout, LOout, MDRout, InPortout, Cout,
   output logic       MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin, outPortenable,
   output logic       Gra, Grb, Grc, Rin, Rout, BAout,
   output logic       IncPC, Read, Write, ConIn
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef enum logic [4:0] {
      C_ALU, C_IMM, C_NEGNOT, C_MULDIV, C_LD, C_LDI, C_ST, C_BR, C_JR, C_JAL,
      C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_ILL, C_HALT
   } cls_t;

   state_t     state, state_nxt;
   cls_t       cls, cls_nxt;
   logic [1:0] wait_cnt, wait_nxt;
   logic       con_q, con_nxt;
   logic       done;

   // Map an opcode to its execute-sequence class; unused codes become C_ILL.
   function automatic cls_t decode(input logic [4:0] op);
      case (op)
         5'b00000:                               return C_LD;
         5'b00001:                               return C_LDI;
         5'b00010:                               return C_ST;
         5'b00011, 5'b00100, 5'b00101, 5'b00110,
         5'b00111, 5'b01000, 5'b01001, 5'b01010,
         5'b01011:                               return C_ALU;
         5'b01100, 5'b01101, 5'b01110:           return C_IMM;
         5'b01111, 5'b10000:                     return C_MULDIV;
         5'b10001, 5'b10010:                     return C_NEGNOT;
         5'b10011:                               return C_BR;
         5'b10100:                               return C_JR;
         5'b10101:                               return C_JAL;
         5'b10110:                               return C_IN;
         5'b10111:                               return C_OUT;
         5'b11000:                               return C_MFHI;
         5'b11001:                               return C_MFLO;
         5'b11010:                               return C_NOP;
         5'b11011:                               return C_HALT;
         default:                                return C_ILL;
      endcase
   endfunction

   // State, captured class, memory-wait counter and branch flag; clear forces the pre-fetch idle state.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state    <= S_IDLE;
         cls      <= C_NOP;
         wait_cnt <= 2'd0;
         con_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cls      <= cls_nxt;
         wait_cnt <= wait_nxt;
         con_q    <= con_nxt;
      end
   end

   // Next-state and strobe decode from the registered state and class only.
   // The opcode is captured on the edge entering T3. CON is captured on the edge entering T6,
   // so that the branch PCin strobe stays a pure function of registers.
   always_comb begin
      state_nxt = state;
      cls_nxt   = cls;
      wait_nxt  = wait_cnt;
      con_nxt   = con_q;
      done      = 1'b0;
      illegal = 1'b0;
      PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIout = 1'b0; LOout = 1'b0;
      MDRout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
      MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
      Zin_low = 1'b0; Zin_high = 1'b0; HIin = 1'b0; LOin = 1'b0; outPortenable = 1'b0;
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      IncPC = 1'b0; Read = 1'b0; Write = 1'b0; ConIn = 1'b0;
      Run = (state != S_IDLE) && (state != S_HALT);

      case (state)
         S_IDLE: state_nxt = S_T0;
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1;
            state_nxt = S_T1;
            wait_nxt  = 2'(MEM_WAIT);
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            if (wait_cnt == 2'd0) state_nxt = S_T2;
            else                  wait_nxt  = wait_cnt - 2'd1;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            state_nxt = S_T3;
            cls_nxt   = decode(opcode);
         end
         S_T3: begin
            state_nxt = S_T4;
            case (cls)
               C_ALU, C_IMM:       begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               C_LD, C_LDI, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               C_NEGNOT:           begin Grb = 1'b1; Rout = 1'b1; Zin_low = 1'b1; end
               C_MULDIV:           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               C_BR:               begin Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1; end
               C_JAL:              begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
               C_JR:               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; done = 1'b1; end
               C_IN:               begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
               C_OUT:              begin Gra = 1'b1; Rout = 1'b1; outPortenable = 1'b1; done = 1'b1; end
               C_MFHI:             begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
               C_MFLO:             begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
               C_ILL:              begin illegal = 1'b1; done = 1'b1; end
               C_HALT:             state_nxt = S_HALT;
               default:            done = 1'b1;
            endcase
         end
         S_T4: begin
            state_nxt = S_T5;
            case (cls)
               C_ALU:                     begin Grc = 1'b1; Rout = 1'b1; Zin_low = 1'b1; end
               C_IMM, C_LD, C_LDI, C_ST:  begin Cout = 1'b1; Zin_low = 1'b1; end
               C_NEGNOT:                  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
               C_MULDIV:                  begin Grb = 1'b1; Rout = 1'b1; Zin_low = 1'b1; Zin_high = 1'b1; end
               C_BR:                      begin PCout = 1'b1; Yin = 1'b1; end
               C_JAL:                     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; done = 1'b1; end
               default:                   done = 1'b1;
            endcase
         end
         S_T5: begin
            state_nxt = S_T6;
            wait_nxt  = 2'(MEM_WAIT);
            case (cls)
               C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
               C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
               C_MULDIV:            begin Zlowout = 1'b1; LOin = 1'b1; end
               C_BR:                begin Cout = 1'b1; Zin_low = 1'b1; con_nxt = CON; end
               default:             done = 1'b1;
            endcase
         end
         S_T6: begin
            state_nxt = S_T7;
            case (cls)
               C_LD: begin
                  Read = 1'b1; MDRin = 1'b1;
                  if (wait_cnt != 2'd0) begin
                     state_nxt = S_T6;
                     wait_nxt  = wait_cnt - 2'd1;
                  end
               end
               C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
               C_BR:     begin Zlowout = con_q; PCin = con_q; done = 1'b1; end
               default:  done = 1'b1;
            endcase
         end
         S_T7: begin
            done = 1'b1;
            case (cls)
               C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_ST:    Write = 1'b1;
               default: ;
            endcase
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase

      if (done) state_nxt = Stop ? S_HALT : S_T0;
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe vectors against hand-built expectations.
// Latency: the clock is free-running, inputs change on negedges and outputs are sampled on negedges.
// Backpressure: none, and every wait is a fixed cycle count.
module tb_control_sequencer;

   logic       Clock = 1'b0;
   logic       clear = 1'b0;
   logic [4:0] opcode = 5'b11010;
   logic       CON = 1'b0;
   logic       Stop = 1'b0;
   logic Run, illegal;
   logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout, InPortout, Cout;
   logic MARin, PCin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin, outPortenable;
   logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write, ConIn;

   control_sequencer #(.MEM_WAIT(1)) dut (
      .Clock(Clock), .clear(clear), .opcode(opcode), .CON(CON), .Stop(Stop),
      .Run(Run), .illegal(illegal),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
      .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .Zin_low(Zin_low), .Zin_high(Zin_high), .HIin(HIin), .LOin(LOin), .outPortenable(outPortenable),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .IncPC(IncPC), .Read(Read), .Write(Write), .ConIn(ConIn)
   );

   always #5 Clock = ~Clock;

   localparam logic [29:0] B_PCOUT    = 30'd1 << 0;
   localparam logic [29:0] B_ZLOWOUT  = 30'd1 << 1;
   localparam logic [29:0] B_ZHIGHOUT = 30'd1 << 2;
   localparam logic [29:0] B_HIOUT    = 30'd1 << 3;
   localparam logic [29:0] B_LOOUT    = 30'd1 << 4;
   localparam logic [29:0] B_MDROUT   = 30'd1 << 5;
   localparam logic [29:0] B_INPORT   = 30'd1 << 6;
   localparam logic [29:0] B_COUT     = 30'd1 << 7;
   localparam logic [29:0] B_MARIN    = 30'd1 << 8;
   localparam logic [29:0] B_PCIN     = 30'd1 << 9;
   localparam logic [29:0] B_MDRIN    = 30'd1 << 10;
   localparam logic [29:0] B_IRIN     = 30'd1 << 11;
   localparam logic [29:0] B_YIN      = 30'd1 << 12;
   localparam logic [29:0] B_ZINL     = 30'd1 << 13;
   localparam logic [29:0] B_ZINH     = 30'd1 << 14;
   localparam logic [29:0] B_HIIN     = 30'd1 << 15;
   localparam logic [29:0] B_LOIN     = 30'd1 << 16;
   localparam logic [29:0] B_OUTPORT  = 30'd1 << 17;
   localparam logic [29:0] B_GRA      = 30'd1 << 18;
   localparam logic [29:0] B_GRB      = 30'd1 << 19;
   localparam logic [29:0] B_GRC      = 30'd1 << 20;
   localparam logic [29:0] B_RIN      = 30'd1 << 21;
   localparam logic [29:0] B_ROUT     = 30'd1 << 22;
   localparam logic [29:0] B_BAOUT    = 30'd1 << 23;
   localparam logic [29:0] B_INCPC    = 30'd1 << 24;
   localparam logic [29:0] B_READ     = 30'd1 << 25;
   localparam logic [29:0] B_WRITE    = 30'd1 << 26;
   localparam logic [29:0] B_CONIN    = 30'd1 << 27;
   localparam logic [29:0] B_RUN      = 30'd1 << 28;
   localparam logic [29:0] B_ILLEGAL  = 30'd1 << 29;

   wire [29:0] obs = {illegal, Run, ConIn, Write, Read, IncPC, BAout, Rout, Rin, Grc, Grb, Gra,
                      outPortenable, LOin, HIin, Zin_high, Zin_low, Yin, IRin, MDRin, PCin, MARin,
                      Cout, InPortout, MDRout, LOout, HIout, Zhighout, Zlowout, PCout};

   int tests_run = 0;
   int tests_failed = 0;
   logic [29:0] exp_q[$];

   task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected cycle while the sequencer is running.
   task automatic step(input logic [29:0] v);
      exp_q.push_back(v | B_RUN);
   endtask

   // Expected cycle with every output low (reset or HALT).
   task automatic idle_cyc();
      exp_q.push_back(30'd0);
   endtask

   // Fetch sequence with MEM_WAIT=1, so the T1 cycle appears twice.
   task automatic fetch();
      step(B_PCOUT | B_MARIN | B_INCPC | B_ZINL);
      step(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN);
      step(B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN);
      step(B_MDROUT | B_IRIN);
   endtask

   // Drive one instruction and check every queued cycle. Stop is raised only after the T0 check,
   // so it applies to this instruction's boundary rather than the previous one.
   task automatic run_seq(input string tag, input logic [4:0] op, input logic con, input logic stop);
      int n;
      opcode = op;
      CON    = con;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         chk($sformatf("%s[%0d]", tag, i), obs, exp_q[i]);
         if (i == 0) Stop = stop;
      end
      exp_q.delete();
   endtask

   task automatic pulse_clear(input string tag);
      @(negedge Clock);
      Stop  = 1'b0;
      clear = 1'b0;
      #1 chk({tag, "_clr"}, obs, 30'd0);
      @(negedge Clock);
      clear = 1'b1;
   endtask

   initial begin
      // Reset state: every output low, including Run.
      repeat (3) @(negedge Clock);
      chk("reset", obs, 30'd0);
      clear = 1'b1;

      // add: 7 cycles, with the write-back strobes only in the last cycle.
      fetch();
      step(B_GRB | B_ROUT | B_YIN);
      step(B_GRC | B_ROUT | B_ZINL);
      step(B_ZLOWOUT | B_GRA | B_RIN);
      run_seq("add", 5'b00011, 1'b0, 1'b0);

      // ld: Read for 2 cycles in T1 and 2 in T6, 10 cycles in total.
      fetch();
      step(B_GRB | B_BAOUT | B_YIN);
      step(B_COUT | B_ZINL);
      step(B_ZLOWOUT | B_MARIN);
      step(B_READ | B_MDRIN);
      step(B_READ | B_MDRIN);
      step(B_MDROUT | B_GRA | B_RIN);
      run_seq("ld", 5'b00000, 1'b0, 1'b0);

      // br not taken: T6 carries no strobes.
      fetch();
      step(B_GRA | B_ROUT | B_CONIN);
      step(B_PCOUT | B_YIN);
      step(B_COUT | B_ZINL);
      step(30'd0);
      run_seq("br0", 5'b10011, 1'b0, 1'b0);

      // br taken.
      fetch();
      step(B_GRA | B_ROUT | B_CONIN);
      step(B_PCOUT | B_YIN);
      step(B_COUT | B_ZINL);
      step(B_ZLOWOUT | B_PCIN);
      run_seq("br1", 5'b10011, 1'b1, 1'b0);

      // mul: both Z halves load in T4, LO in T5 and HI in T6.
      fetch();
      step(B_GRA | B_ROUT | B_YIN);
      step(B_GRB | B_ROUT | B_ZINL | B_ZINH);
      step(B_ZLOWOUT | B_LOIN);
      step(B_ZHIGHOUT | B_HIIN);
      run_seq("mul", 5'b10000, 1'b0, 1'b0);

      // addi.
      fetch();
      step(B_GRB | B_ROUT | B_YIN);
      step(B_COUT | B_ZINL);
      step(B_ZLOWOUT | B_GRA | B_RIN);
      run_seq("addi", 5'b01100, 1'b0, 1'b0);

      // not.
      fetch();
      step(B_GRB | B_ROUT | B_ZINL);
      step(B_ZLOWOUT | B_GRA | B_RIN);
      run_seq("not", 5'b10010, 1'b0, 1'b0);

      // jal.
      fetch();
      step(B_PCOUT | B_GRB | B_RIN);
      step(B_GRA | B_ROUT | B_PCIN);
      run_seq("jal", 5'b10101, 1'b0, 1'b0);

      // mfhi.
      fetch();
      step(B_HIOUT | B_GRA | B_RIN);
      run_seq("mfhi", 5'b11000, 1'b0, 1'b0);

      // out.
      fetch();
      step(B_GRA | B_ROUT | B_OUTPORT);
      run_seq("out", 5'b10111, 1'b0, 1'b0);

      // st with Stop: the instruction completes, Write pulses in T7, then HALT holds.
      fetch();
      step(B_GRB | B_BAOUT | B_YIN);
      step(B_COUT | B_ZINL);
      step(B_ZLOWOUT | B_MARIN);
      step(B_GRA | B_ROUT | B_MDRIN);
      step(B_WRITE);
      idle_cyc();
      idle_cyc();
      idle_cyc();
      run_seq("st_stop", 5'b00010, 1'b0, 1'b1);
      pulse_clear("st");

      // halt opcode: an empty T3, then HALT.
      fetch();
      step(30'd0);
      idle_cyc();
      idle_cyc();
      run_seq("halt", 5'b11011, 1'b0, 1'b0);
      pulse_clear("halt");

      // sub interrupted by clear in T4: outputs drop within the same cycle.
      fetch();
      step(B_GRB | B_ROUT | B_YIN);
      step(B_GRC | B_ROUT | B_ZINL);
      run_seq("sub", 5'b00100, 1'b0, 1'b0);
      #1 clear = 1'b0;
      #1 chk("sub_async_clr", obs, 30'd0);
      @(negedge Clock);
      chk("sub_clr_hold", obs, 30'd0);
      clear = 1'b1;

      // Restart from T0 with an undefined opcode, which gives an illegal pulse only in T3.
      fetch();
      step(B_ILLEGAL);
      run_seq("ill", 5'b11111, 1'b0, 1'b0);

      // nop: the preceding illegal instruction returned to fetch normally.
      fetch();
      step(30'd0);
      run_seq("nop", 5'b11010, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
